// File: rtl/fios_feeder_pkg.sv
// Shared types and constants for the FIOS host feeder.
// The optional watchdog is enabled with `define FIOS_FEEDER_TIMEOUT_EN.
package fios_feeder_pkg;

    localparam int WORD_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_OUT
    } feeder_state_t;

    localparam logic [1:0] SEL_A      = 2'd0;
    localparam logic [1:0] SEL_B      = 2'd1;
    localparam logic [1:0] SEL_P      = 2'd2;
    localparam logic [1:0] SEL_PPRIME = 2'd3;

    // A storage rounded up to a whole number of PE windows
    function automatic int a_words(input int s, input int pe_nb);
        return ((s - 1) / pe_nb + 1) * pe_nb;
    endfunction

endpackage

// File: rtl/fios_word_shift_reg.sv
// Word-addressable register file that can also shift down by SHIFT words,
// zero-filling the top; used for the A operand window.
module fios_word_shift_reg #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17,
    parameter int SHIFT = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   shift,
    output logic [DEPTH*WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (shift) begin
            for (int unsigned i = 0; i < DEPTH - SHIFT; i++) mem[i] <= mem[i + SHIFT];
            for (int unsigned i = DEPTH - SHIFT; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        q = '0;
        for (int unsigned i = 0; i < DEPTH; i++) q[i*WIDTH +: WIDTH] = mem[i];
    end

endmodule

// File: rtl/fios_host_feeder.sv
// Host-side feeder for the FIOS Montgomery core: operand storage, core fetch
// service and result streaming. Optional watchdog: `define FIOS_FEEDER_TIMEOUT_EN.
module fios_host_feeder
    import fios_feeder_pkg::*;
#(
    parameter int s              = 8,
    parameter int PE_NB          = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int A_WORDS = ((s - 1) / PE_NB + 1) * PE_NB,
    localparam int AW      = (A_WORDS > 1) ? $clog2(A_WORDS) : 1
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      ld_valid_i,
    input  logic [1:0]                ld_sel_i,
    input  logic [AW-1:0]             ld_addr_i,
    input  logic [WORD_W-1:0]         ld_data_i,
    input  logic                      go_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      start_o,
    output logic [PE_NB*WORD_W-1:0]   a_o,
    output logic [WORD_W-1:0]         b_o,
    output logic [WORD_W-1:0]         p_o,
    output logic [WORD_W-1:0]         p_prime_0_o,
    input  logic                      a_shift_i,
    input  logic                      b_fetch_i,
    input  logic                      p_fetch_i,
    input  logic                      res_push_i,
    input  logic [WORD_W-1:0]         res_i,
    input  logic                      done_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [WORD_W-1:0]         res_data_o,
    output logic                      res_last_o
);

    localparam int PW = (s > 1) ? $clog2(s) : 1;
    localparam int CW = $clog2(s + 1);

    feeder_state_t state, state_next;

    logic [PW-1:0]     b_ptr, p_ptr, rd_ptr;
    logic [CW-1:0]     res_cnt;
    logic              err, err_next;
    logic [WORD_W-1:0] b_mem   [s];
    logic [WORD_W-1:0] p_mem   [s];
    logic [WORD_W-1:0] res_mem [s];
    logic [WORD_W-1:0] p_prime;
    logic [A_WORDS*WORD_W-1:0] a_q;

    logic addr_in_s, addr_in_a;
    logic wr_a, wr_b, wr_p, wr_pp, clr_ptrs;
    logic do_shift, b_adv, p_adv, push_ok, rd_adv;
    logic timeout;

`ifdef FIOS_FEEDER_TIMEOUT_EN
    logic [31:0] wdog;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)                           wdog <= '0;
        else if (state != ST_RUN || res_push_i) wdog <= '0;
        else                                   wdog <= wdog + 32'd1;
    end

    assign timeout = (wdog == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign addr_in_s = (int'(ld_addr_i) < s);
    assign addr_in_a = (int'(ld_addr_i) < A_WORDS);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        err_next    = err;
        wr_a        = 1'b0;
        wr_b        = 1'b0;
        wr_p        = 1'b0;
        wr_pp       = 1'b0;
        clr_ptrs    = 1'b0;
        do_shift    = 1'b0;
        b_adv       = 1'b0;
        p_adv       = 1'b0;
        push_ok     = 1'b0;
        rd_adv      = 1'b0;
        start_o     = 1'b0;
        busy_o      = (state != ST_IDLE);
        res_valid_o = 1'b0;
        res_last_o  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ld_valid_i) begin
                    wr_a  = (ld_sel_i == SEL_A) && addr_in_a;
                    wr_b  = (ld_sel_i == SEL_B) && addr_in_s;
                    wr_p  = (ld_sel_i == SEL_P) && addr_in_s;
                    wr_pp = (ld_sel_i == SEL_PPRIME);
                end
                if (go_i) begin
                    state_next = ST_START;
                    err_next   = 1'b0;
                    clr_ptrs   = 1'b0 | 1'b1;
                end
            end
            ST_START: begin
                start_o    = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                do_shift = a_shift_i;
                b_adv    = b_fetch_i;
                p_adv    = p_fetch_i;
                if (res_push_i) begin
                    if (res_cnt == CW'(s)) err_next = 1'b1;
                    else                   push_ok  = 1'b1;
                end
                // a push in the same cycle as done counts toward completion
                if (done_i) begin
                    if ((res_cnt + CW'(push_ok)) == CW'(s)) begin
                        state_next = ST_OUT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (timeout && !res_push_i) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_OUT: begin
                res_valid_o = 1'b1;
                res_last_o  = (rd_ptr == PW'(s - 1));
                if (res_ready_i) begin
                    rd_adv = 1'b1;
                    if (res_last_o) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (busy_o && ld_valid_i) err_next = 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            err     <= 1'b0;
            b_ptr   <= '0;
            p_ptr   <= '0;
            rd_ptr  <= '0;
            res_cnt <= '0;
            p_prime <= '0;
            for (int unsigned i = 0; i < s; i++) begin
                b_mem[i]   <= '0;
                p_mem[i]   <= '0;
                res_mem[i] <= '0;
            end
        end else begin
            err <= err_next;
            if (clr_ptrs) begin
                b_ptr   <= '0;
                p_ptr   <= '0;
                rd_ptr  <= '0;
                res_cnt <= '0;
            end
            if (wr_b)  b_mem[PW'(ld_addr_i)] <= ld_data_i;
            if (wr_p)  p_mem[PW'(ld_addr_i)] <= ld_data_i;
            if (wr_pp) p_prime <= ld_data_i;
            if (b_adv) b_ptr <= (b_ptr == PW'(s - 1)) ? '0 : b_ptr + PW'(1);
            if (p_adv) p_ptr <= (p_ptr == PW'(s - 1)) ? '0 : p_ptr + PW'(1);
            if (push_ok) begin
                res_mem[res_cnt[PW-1:0]] <= res_i;
                res_cnt <= res_cnt + CW'(1);
            end
            if (rd_adv) rd_ptr <= (rd_ptr == PW'(s - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    fios_word_shift_reg #(
        .DEPTH (A_WORDS),
        .WIDTH (WORD_W),
        .SHIFT (PE_NB)
    ) u_a_reg (
        .clk     (clock_i),
        .rst     (reset_i),
        .wr_en   (wr_a),
        .wr_addr (ld_addr_i),
        .wr_data (ld_data_i),
        .shift   (do_shift),
        .q       (a_q)
    );

    assign a_o         = a_q[PE_NB*WORD_W-1:0];
    assign b_o         = b_mem[b_ptr];
    assign p_o         = p_mem[p_ptr];
    assign p_prime_0_o = p_prime;
    assign err_o       = err;
    assign res_data_o  = res_mem[rd_ptr];

endmodule

// File: doc/fios_host_feeder.md
Name: fios_host_feeder

Overview:
- Host-side counterpart of the FIOS Montgomery core interface.
- Holds the A, B and P operand words and p'0. Issues start to the core. Serves the core's a_shift / b_fetch / p_fetch requests and collects result words on RES_push / done.
- Sits between a host word-load port and the FIOS core; streams the s-word result back to the host with a valid/ready handshake.

Parameters:
- s, 8, number of 17-bit words per operand.
- PE_NB, 8, core PE count; width of the A window in words; words dropped per a_shift.
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only).

Ports:
- clock_i in 1: clock.
- reset_i in 1: asynchronous active-high reset.
- ld_valid_i in 1: host word write strobe.
- ld_sel_i in 2: target select; 0=A, 1=B, 2=P, 3=p'0.
- ld_addr_i in $clog2(A_WORDS): word index; ignored when sel=3.
- ld_data_i in 17: write data.
- go_i in 1: request a multiplication.
- busy_o out 1: high in any state other than IDLE.
- err_o out 1: sticky protocol error.
- start_o out 1: start pulse to the core.
- a_o out PE_NB*17: A window; word k at bits [17k+16:17k].
- b_o out 17: current B word to the core.
- p_o out 17: current P word to the core.
- p_prime_0_o out 17: p'0 register.
- a_shift_i in 1: core request to advance the A window.
- b_fetch_i in 1: core consumed the current B word.
- p_fetch_i in 1: core consumed the current P word.
- res_push_i in 1: result word valid from core.
- res_i in 17: result word from core.
- done_i in 1: core finished.
- res_valid_o out 1: result stream valid.
- res_ready_i in 1: result stream ready.
- res_data_o out 17: result stream data.
- res_last_o out 1: marks word s-1 of the result stream.

Behaviour:
- A_WORDS = ((s-1)/PE_NB+1)*PE_NB.
- Storage: A shift register (A_WORDS x 17), B and P arrays (s x 17), RES array (s x 17).
- Reset (asynchronous): state IDLE; all pointers and counters 0; every output 0. Stored operands need not be reset.
- FSM states: IDLE, START, RUN, OUT.
  - IDLE:
    - ld_valid_i writes the selected word; addresses >= s (>= A_WORDS for A) are ignored.
    - go_i → START; clears err_o; b_ptr=p_ptr=res_cnt=0.
  - START: start_o=1 for exactly one cycle → RUN.
  - RUN:
    - a_shift_i: A shifts down by PE_NB words, zero-filled at the top.
    - b_fetch_i: b_ptr advances; wraps s-1→0. p_fetch_i: same for p_ptr, independently.
    - b_o=B[b_ptr] and p_o=P[p_ptr], combinational from the pointer; new word visible the cycle after the fetch.
    - res_push_i: RES[res_cnt]<=res_i, res_cnt++.
    - done_i: if res_cnt (including a same-cycle push) == s → OUT; otherwise set err_o → IDLE.
  - OUT:
    - res_valid_o=1, res_data_o=RES[rd_ptr], res_last_o=(rd_ptr==s-1).
    - valid&&ready advances rd_ptr; the transfer with res_last_o → IDLE.
- a_o = lowest PE_NB words of the A register at all times.
- Boundary and error conditions:
  - res_push_i while res_cnt==s: word dropped, err_o set, stays in RUN.
  - go_i while busy_o: ignored; err_o unchanged.
  - ld_valid_i while busy_o: write ignored, err_o set.
  - res_push_i and done_i in the same cycle: push captured first, then done evaluated.
  - Core strobes (a_shift_i, fetches, pushes, done_i) outside RUN: ignored.
- Latency: go_i → start_o one cycle later. Last result accepted → busy_o low the next cycle.

Optional Feature:
- Macro: FIOS_FEEDER_TIMEOUT_EN.
- Defined: a 32-bit watchdog counts cycles in RUN and clears on every res_push_i. On reaching TIMEOUT_CYCLES: err_o set, state → IDLE, no result stream.
- Not defined: no counter; RUN waits indefinitely.

Decomposition:
- Package fios_feeder_pkg: state enum, ld_sel encoding constants (SEL_A/B/P/PPRIME), word width constant 17.
- One natural sub-module: fios_word_shift_reg (parameterized depth/width shift-by-N register with per-word write) for A storage.

Test Plan:
1. s=4, PE_NB=2; load A=1..4, B=5..8, P=9..12, p'0=0x1ABCD; go_i → single-cycle start_o one cycle later; a_o={2,1}; after one a_shift_i, a_o={4,3}; after a second, a_o={0,0}.
2. Five b_fetch_i pulses → b_o sequence 5,6,7,8,5 (wrap); p_o stays 9 with no p_fetch_i.
3. Push res 0x10,0x11,0x12,0x13, then done_i → res_valid_o; with res_ready_i toggling 1,0,1,1,1 the stream is 0x10..0x13, res_last_o only on 0x13, then busy_o=0.
4. done_i after 3 pushes → err_o=1, IDLE, no res_valid_o; next go_i clears err_o.
5. 5th res_push_i in RUN → err_o=1, RES[0..3] unchanged. go_i and ld_valid_i during RUN → no second start_o, storage unchanged.
6. Assert reset_i mid-RUN and mid-OUT, off-clock-edge → all outputs 0 immediately. With FIOS_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no core response → err_o at cycle 16 of RUN.
